// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with a sequential post-reset clear
// engine, optional write-to-read bypass and a per-register pending scoreboard.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 1,
  parameter int INIT_IDX = 0,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_busy,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*XLEN-1:0]   rdata,
  output logic [NUM_RD-1:0]        rpend,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd
);

  localparam logic LP_BYP  = (BYPASS != 0);
  localparam logic LP_ZERO = (ZERO_R0 != 0);
  localparam logic LP_IDX  = (INIT_IDX != 0);

  generate
    if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_regs
      $error("regfile_mp: NUM_REGS must be a power of 2 and >= 2");
    end
    if (NUM_RD < 1) begin : g_bad_rd
      $error("regfile_mp: NUM_RD must be >= 1");
    end
  endgenerate

  logic [XLEN-1:0]     r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_next;
  logic                r_busy;
  logic [AW-1:0]       r_cnt;

  logic                w_wr_acc;
  logic                w_iss_acc;
  logic [XLEN-1:0]     w_init_val;
  logic                w_mem_we;
  logic [AW-1:0]       w_mem_addr;
  logic [XLEN-1:0]     w_mem_din;

  // Writes to x0 are dropped up front so the bypass and scoreboard never see them.
  assign w_wr_acc   = we & ~r_busy & ~(LP_ZERO & (waddr == '0));
  assign w_iss_acc  = issue_valid & ~r_busy & ~(LP_ZERO & (issue_rd == '0));
  assign w_init_val = LP_IDX ? XLEN'(r_cnt) : '0;

  // The clear engine and writeback share one storage write port.
  assign w_mem_we   = ~rst & (r_busy | w_wr_acc);
  assign w_mem_addr = r_busy ? r_cnt : waddr;
  assign w_mem_din  = r_busy ? w_init_val : wdata;

  assign init_busy  = r_busy;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + AW'(1);
      if (r_cnt == AW'(NUM_REGS - 1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  // A newly issued producer outranks the retiring one on the same register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      assign w_pend_next[gi] =
        (w_iss_acc && issue_rd == AW'(gi)) ? 1'b1 :
        (w_wr_acc && waddr == AW'(gi))     ? 1'b0 :
                                             r_pend[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_hit;
      logic          w_zero;

      assign w_addr = raddr[gi*AW +: AW];
      assign w_hit  = LP_BYP & w_wr_acc & (waddr == w_addr);
      assign w_zero = LP_ZERO & (w_addr == '0);

      assign rdata[gi*XLEN +: XLEN] =
        (r_busy || w_zero) ? '0 :
        w_hit              ? wdata :
                             r_mem[w_addr];

      assign rpend[gi] = ~r_busy & r_pend[w_addr] & ~w_hit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: instance a uses defaults (bypass, x0 hardwired, zero clear);
// instance b has no bypass, writable x0 and index-valued clear.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;

  logic        busy_a, busy_b;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rpend_a, rpend_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1), .ZERO_R0(1), .INIT_IDX(0)) u_a (
    .clk(clk), .rst(rst), .init_busy(busy_a), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .rpend(rpend_a), .issue_valid(issue_valid), .issue_rd(issue_rd)
  );

  regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(0), .ZERO_R0(0), .INIT_IDX(1)) u_b (
    .clk(clk), .rst(rst), .init_busy(busy_b), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rpend(rpend_b), .issue_valid(issue_valid), .issue_rd(issue_rd)
  );

  wire [31:0] a_rd0 = rdata_a[31:0];
  wire [31:0] a_rd1 = rdata_a[63:32];
  wire [31:0] b_rd0 = rdata_b[31:0];
  wire [31:0] b_rd1 = rdata_b[63:32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p0, input int p1);
    raddr[4:0] = 5'(p0);
    raddr[9:5] = 5'(p1);
  endtask

  // Waits for both instances to leave the clear phase; returns edge count.
  task automatic wait_clear(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy_a || busy_b) && n < 40);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL reset_busy_a: got %b want 1", busy_a); end
    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL reset_busy_b: got %b want 1", busy_b); end
    wait_clear(n);
    total++; if (n !== 32) begin bad++; $display("FAIL reset_busy_len: got %0d edges want 32", n); end
    for (int i = 0; i < 32; i++) begin
      set_rd(i, 31 - i);
      #1;
      total++; if (a_rd0 !== 32'h0) begin bad++; $display("FAIL reset_a_r%0d: got %h want 0", i, a_rd0); end
      total++; if (b_rd0 !== 32'(i)) begin bad++; $display("FAIL reset_b_r%0d: got %h want %h", i, b_rd0, 32'(i)); end
      total++; if (b_rd1 !== 32'(31 - i)) begin bad++; $display("FAIL reset_b_p1_r%0d: got %h want %h", 31 - i, b_rd1, 32'(31 - i)); end
    end
    $display("reset: clear took %0d edges", n);
  endtask

  task automatic test_restart();
    int n;
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000AAAA;
    tick();
    waddr = 5'd20; wdata = 32'h0000BBBB;
    tick();
    we = 1'b0;
    set_rd(3, 20);
    #1;
    total++; if (a_rd0 !== 32'h0000AAAA) begin bad++; $display("FAIL restart_pre_r3: got %h want 0000aaaa", a_rd0); end
    total++; if (a_rd1 !== 32'h0000BBBB) begin bad++; $display("FAIL restart_pre_r20: got %h want 0000bbbb", a_rd1); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL restart_mid_busy: got %b want 1", busy_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear(n);
    total++; if (n !== 32) begin bad++; $display("FAIL restart_busy_len: got %0d edges want 32", n); end
    for (int i = 0; i < 10; i++) begin
      set_rd(i, 20);
      #1;
      total++; if (a_rd0 !== 32'h0) begin bad++; $display("FAIL restart_a_r%0d: got %h want 0", i, a_rd0); end
      total++; if (b_rd0 !== 32'(i)) begin bad++; $display("FAIL restart_b_r%0d: got %h want %h", i, b_rd0, 32'(i)); end
    end
    total++; if (a_rd1 !== 32'h0) begin bad++; $display("FAIL restart_a_r20: got %h want 0", a_rd1); end
    total++; if (b_rd1 !== 32'd20) begin bad++; $display("FAIL restart_b_r20: got %h want 14", b_rd1); end
    $display("restart: second clear took %0d edges", n);
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd5; wdata = 32'h11111111;
    tick();
    wdata = 32'hDEADBEEF;
    set_rd(5, 5);
    #1;
    total++; if (a_rd0 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_a_same: got %h want deadbeef", a_rd0); end
    total++; if (b_rd0 !== 32'h11111111) begin bad++; $display("FAIL bypass_b_same: got %h want 11111111", b_rd0); end
    tick();
    we = 1'b0;
    #1;
    total++; if (a_rd0 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_a_next: got %h want deadbeef", a_rd0); end
    total++; if (b_rd0 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_b_next: got %h want deadbeef", b_rd0); end
    $display("bypass: write r5=deadbeef a_same=%h b_same_after=%h", a_rd0, b_rd0);
  endtask

  task automatic test_zero();
    we = 1'b1; waddr = 5'd0; wdata = 32'h00001234;
    set_rd(0, 0);
    #1;
    total++; if (a_rd0 !== 32'h0) begin bad++; $display("FAIL zero_a_bypass: got %h want 0", a_rd0); end
    tick();
    we = 1'b0;
    #1;
    total++; if (a_rd0 !== 32'h0) begin bad++; $display("FAIL zero_a_p0: got %h want 0", a_rd0); end
    total++; if (a_rd1 !== 32'h0) begin bad++; $display("FAIL zero_a_p1: got %h want 0", a_rd1); end
    total++; if (rpend_a !== 2'b00) begin bad++; $display("FAIL zero_a_pend: got %b want 00", rpend_a); end
    total++; if (b_rd0 !== 32'h00001234) begin bad++; $display("FAIL zero_b_p0: got %h want 00001234", b_rd0); end
    total++; if (b_rd1 !== 32'h00001234) begin bad++; $display("FAIL zero_b_p1: got %h want 00001234", b_rd1); end
    $display("zero: write x0=1234 a_reads=%h b_reads=%h", a_rd0, b_rd0);
  endtask

  task automatic test_pend();
    issue_valid = 1'b1; issue_rd = 5'd3;
    set_rd(0, 3);
    #1;
    total++; if (rpend_a[1] !== 1'b0) begin bad++; $display("FAIL pend_not_yet: got %b want 0", rpend_a[1]); end
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (rpend_a[1] !== 1'b1) begin bad++; $display("FAIL pend_set_a: got %b want 1", rpend_a[1]); end
    total++; if (rpend_b[1] !== 1'b1) begin bad++; $display("FAIL pend_set_b: got %b want 1", rpend_b[1]); end
    total++; if (rpend_a[0] !== 1'b0) begin bad++; $display("FAIL pend_other_port: got %b want 0", rpend_a[0]); end
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000033;
    #1;
    total++; if (rpend_a[1] !== 1'b0) begin bad++; $display("FAIL pend_byp_a: got %b want 0", rpend_a[1]); end
    total++; if (rpend_b[1] !== 1'b1) begin bad++; $display("FAIL pend_nobyp_b: got %b want 1", rpend_b[1]); end
    total++; if (a_rd1 !== 32'h00000033) begin bad++; $display("FAIL pend_byp_data: got %h want 00000033", a_rd1); end
    tick();
    we = 1'b0;
    #1;
    total++; if (rpend_a[1] !== 1'b0) begin bad++; $display("FAIL pend_clr_a: got %b want 0", rpend_a[1]); end
    total++; if (rpend_b[1] !== 1'b0) begin bad++; $display("FAIL pend_clr_b: got %b want 0", rpend_b[1]); end
    issue_valid = 1'b1; issue_rd = 5'd3;
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000044;
    tick();
    issue_valid = 1'b0; we = 1'b0;
    #1;
    total++; if (rpend_a[1] !== 1'b1) begin bad++; $display("FAIL pend_setwins_a: got %b want 1", rpend_a[1]); end
    total++; if (rpend_b[1] !== 1'b1) begin bad++; $display("FAIL pend_setwins_b: got %b want 1", rpend_b[1]); end
    total++; if (a_rd1 !== 32'h00000044) begin bad++; $display("FAIL pend_setwins_data: got %h want 00000044", a_rd1); end
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000055;
    tick();
    we = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (rpend_a !== 2'b00) begin bad++; $display("FAIL pend_x0_a: got %b want 00", rpend_a); end
    total++; if (rpend_b !== 2'b01) begin bad++; $display("FAIL pend_x0_b: got %b want 01", rpend_b); end
    $display("pend: r3 set/clear/set-wins done, x0 issue a=%b b=%b", rpend_a, rpend_b);
  endtask

  task automatic test_back_to_back();
    we = 1'b1;
    for (int i = 10; i < 14; i++) begin
      waddr = 5'(i); wdata = 32'h00001000 + 32'(i);
      tick();
    end
    we = 1'b0;
    for (int i = 10; i < 14; i++) begin
      set_rd(i, i);
      #1;
      total++; if (a_rd0 !== 32'h00001000 + 32'(i)) begin bad++; $display("FAIL b2b_a_r%0d: got %h want %h", i, a_rd0, 32'h00001000 + 32'(i)); end
      total++; if (a_rd1 !== a_rd0) begin bad++; $display("FAIL b2b_dup_r%0d: got %h want %h", i, a_rd1, a_rd0); end
      total++; if (b_rd1 !== 32'h00001000 + 32'(i)) begin bad++; $display("FAIL b2b_b_r%0d: got %h want %h", i, b_rd1, 32'h00001000 + 32'(i)); end
    end
    $display("back_to_back: wrote r10..r13");
  endtask

  task automatic test_busy_block();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; waddr = 5'd4; wdata = 32'h0000FFFF;
    issue_valid = 1'b1; issue_rd = 5'd4;
    set_rd(4, 12);
    n = 0;
    while (n < 40) begin
      #1;
      if (!busy_a) break;
      total++; if (a_rd0 !== 32'h0 || rpend_a !== 2'b00) begin bad++; $display("FAIL busy_a_cyc%0d: got %h/%b want 0/00", n, a_rd0, rpend_a); end
      total++; if (b_rd1 !== 32'h0 || rpend_b !== 2'b00) begin bad++; $display("FAIL busy_b_cyc%0d: got %h/%b want 0/00", n, b_rd1, rpend_b); end
      tick();
      n++;
    end
    we = 1'b0; issue_valid = 1'b0;
    #1;
    total++; if (n !== 32) begin bad++; $display("FAIL busy_len: got %0d edges want 32", n); end
    total++; if (a_rd0 !== 32'h0) begin bad++; $display("FAIL busy_a_r4: got %h want 0", a_rd0); end
    total++; if (b_rd0 !== 32'd4) begin bad++; $display("FAIL busy_b_r4: got %h want 4", b_rd0); end
    total++; if (b_rd1 !== 32'd12) begin bad++; $display("FAIL busy_b_r12: got %h want c", b_rd1); end
    total++; if (rpend_a !== 2'b00 || rpend_b !== 2'b00) begin bad++; $display("FAIL busy_pend: got %b/%b want 00/00", rpend_a, rpend_b); end
    $display("busy_block: we/issue ignored for %0d edges", n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_restart();
    test_bypass();
    test_zero();
    test_pend();
    test_back_to_back();
    test_busy_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
